rvfi_retire_emitter: RTL and testbench

//  Producer end of the RVFI trace consumed by the per-instruction formal checkers.

---
 rtl/rvfi_retire_emitter_pkg.sv | 45 ++++
 rtl/rvfi_retire_emitter_if.sv | 46 ++++
 rtl/rvfi_retire_emitter_pkt_reg.sv | 20 ++
 rtl/rvfi_retire_emitter.sv | 153 +++++++++++++++
 tb/tb_rvfi_retire_emitter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_retire_emitter_pkg.sv
// Shared RVFI types for the retire emitter and the formal checker wrappers:
// packet struct, emitter state, and the machine-mode constant.
package rvfi_retire_emitter_pkg;

    localparam int RVFI_XLEN    = 32;
    localparam int RVFI_ILEN    = 32;
    localparam int RVFI_ORDER_W = 64;

    localparam logic [1:0] RVFI_MODE_M = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } emit_state_t;

    typedef struct packed {
        logic [RVFI_ILEN-1:0]   insn;
        logic [RVFI_XLEN-1:0]   pc_rdata;
        logic [RVFI_XLEN-1:0]   pc_wdata;
        logic [4:0]             rs1_addr;
        logic [4:0]             rs2_addr;
        logic [RVFI_XLEN-1:0]   rs1_rdata;
        logic [RVFI_XLEN-1:0]   rs2_rdata;
        logic [4:0]             rd_addr;
        logic [RVFI_XLEN-1:0]   rd_wdata;
        logic [RVFI_XLEN-1:0]   mem_addr;
        logic [RVFI_XLEN/8-1:0] mem_rmask;
        logic [RVFI_XLEN/8-1:0] mem_wmask;
        logic [RVFI_XLEN-1:0]   mem_rdata;
        logic [RVFI_XLEN-1:0]   mem_wdata;
        logic                   trap;
        logic                   intr;
    } rvfi_pkt_t;

    // Expand a byte mask into a bit mask (bit 8*i..8*i+7 follows mask bit i).
    function automatic logic [RVFI_XLEN-1:0] byte_mask_bits(input logic [RVFI_XLEN/8-1:0] m);
        logic [RVFI_XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < RVFI_XLEN/8; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/rvfi_retire_emitter_if.sv
// Writeback-to-emitter handshake plus the data-memory response and trap-entry
// strobe that complete a retiring instruction.
interface rvfi_retire_emitter_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ILEN-1:0]   wb_insn;
    logic [XLEN-1:0]   wb_pc;
    logic [XLEN-1:0]   wb_npc;
    logic [4:0]        wb_rs1_addr;
    logic [XLEN-1:0]   wb_rs1_data;
    logic [4:0]        wb_rs2_addr;
    logic [XLEN-1:0]   wb_rs2_data;
    logic [4:0]        wb_rd_addr;
    logic [XLEN-1:0]   wb_rd_wdata;
    logic              wb_trap;
    logic              wb_mem_op;
    logic [XLEN-1:0]   wb_mem_addr;
    logic [XLEN/8-1:0] wb_mem_wmask;
    logic [XLEN/8-1:0] wb_mem_rmask;
    logic [XLEN-1:0]   wb_mem_wdata;
    logic              dmem_rsp_valid;
    logic [XLEN-1:0]   dmem_rsp_rdata;
    logic              dmem_rsp_error;
    logic              trap_entry;

    modport master (
        output wb_valid, wb_insn, wb_pc, wb_npc,
               wb_rs1_addr, wb_rs1_data, wb_rs2_addr, wb_rs2_data,
               wb_rd_addr, wb_rd_wdata, wb_trap, wb_mem_op,
               wb_mem_addr, wb_mem_wmask, wb_mem_rmask, wb_mem_wdata,
               dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_error, trap_entry,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_insn, wb_pc, wb_npc,
               wb_rs1_addr, wb_rs1_data, wb_rs2_addr, wb_rs2_data,
               wb_rd_addr, wb_rd_wdata, wb_trap, wb_mem_op,
               wb_mem_addr, wb_mem_wmask, wb_mem_rmask, wb_mem_wdata,
               dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_error, trap_entry,
        output wb_ready
    );
endinterface

// File: rtl/rvfi_retire_emitter_pkt_reg.sv
// RVFI packet register: synchronous clear has priority over load, otherwise holds.
module rvfi_pkt_reg
    import rvfi_retire_emitter_pkg::*;
(
    input  logic      clk,
    input  logic      clear,
    input  logic      load,
    input  rvfi_pkt_t d,
    output rvfi_pkt_t q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rvfi_retire_emitter.sv
// Packs each retired instruction into one registered RVFI packet; loads and
// stores are parked until their data-memory response completes the packet.
module rvfi_retire_emitter
    import rvfi_retire_emitter_pkg::*;
#(
    parameter int                 XLEN      = RVFI_XLEN,
    parameter int                 ILEN      = RVFI_ILEN,
    parameter int                 ORDER_W   = RVFI_ORDER_W,
    parameter logic [ORDER_W-1:0] ORDER_RST = '0
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    rvfi_retire_emitter_if.slave  wb,
    output logic                  rvfi_valid,
    output logic [ORDER_W-1:0]    rvfi_order,
    output logic [ILEN-1:0]       rvfi_insn,
    output logic [XLEN-1:0]       rvfi_pc_rdata,
    output logic [XLEN-1:0]       rvfi_pc_wdata,
    output logic [4:0]            rvfi_rs1_addr,
    output logic [4:0]            rvfi_rs2_addr,
    output logic [XLEN-1:0]       rvfi_rs1_rdata,
    output logic [XLEN-1:0]       rvfi_rs2_rdata,
    output logic [4:0]            rvfi_rd_addr,
    output logic [XLEN-1:0]       rvfi_rd_wdata,
    output logic [XLEN-1:0]       rvfi_mem_addr,
    output logic [XLEN/8-1:0]     rvfi_mem_rmask,
    output logic [XLEN/8-1:0]     rvfi_mem_wmask,
    output logic [XLEN-1:0]       rvfi_mem_rdata,
    output logic [XLEN-1:0]       rvfi_mem_wdata,
    output logic                  rvfi_trap,
    output logic                  rvfi_halt,
    output logic                  rvfi_intr,
    output logic [1:0]            rvfi_mode
);

    emit_state_t        state;
    logic [ORDER_W-1:0] order_q;
    logic               intr_pend;
    rvfi_pkt_t          wb_pkt;
    rvfi_pkt_t          hold_pkt;
    rvfi_pkt_t          rsp_pkt;
    rvfi_pkt_t          out_d;
    rvfi_pkt_t          out_q;
    logic               accept;
    logic               emit_direct;
    logic               emit_rsp;
    logic               emit;

    assign wb.wb_ready  = g_resetn && (state == S_IDLE);
    assign accept       = wb.wb_valid && wb.wb_ready;
    assign emit_direct  = accept && !wb.wb_mem_op;
    assign emit_rsp     = g_resetn && (state == S_HOLD) && wb.dmem_rsp_valid;
    assign emit         = emit_direct || emit_rsp;

    always_comb begin
        wb_pkt           = '0;
        wb_pkt.insn      = wb.wb_insn;
        wb_pkt.pc_rdata  = wb.wb_pc;
        wb_pkt.pc_wdata  = wb.wb_npc;
        wb_pkt.rs1_addr  = wb.wb_rs1_addr;
        wb_pkt.rs2_addr  = wb.wb_rs2_addr;
        wb_pkt.rs1_rdata = wb.wb_rs1_data;
        wb_pkt.rs2_rdata = wb.wb_rs2_data;
        wb_pkt.rd_addr   = wb.wb_rd_addr;
        wb_pkt.trap      = wb.wb_trap;
        if (wb.wb_rd_addr != 5'd0) begin
            wb_pkt.rd_wdata = wb.wb_rd_wdata;
        end
        // Non-memory instructions report an all-zero memory footprint.
        if (wb.wb_mem_op) begin
            wb_pkt.mem_addr  = wb.wb_mem_addr;
            wb_pkt.mem_rmask = wb.wb_mem_rmask;
            wb_pkt.mem_wmask = wb.wb_mem_wmask;
            wb_pkt.mem_wdata = wb.wb_mem_wdata;
        end
    end

    always_comb begin
        rsp_pkt           = hold_pkt;
        rsp_pkt.mem_rdata = wb.dmem_rsp_rdata & byte_mask_bits(hold_pkt.mem_rmask);
        if (wb.dmem_rsp_error) begin
            rsp_pkt.trap     = 1'b1;
            rsp_pkt.rd_addr  = 5'd0;
            rsp_pkt.rd_wdata = '0;
        end
    end

    always_comb begin
        out_d      = emit_rsp ? rsp_pkt : wb_pkt;
        out_d.intr = intr_pend;
    end

    rvfi_pkt_reg u_hold (
        .clk   (g_clk),
        .clear (!g_resetn),
        .load  (accept && wb.wb_mem_op),
        .d     (wb_pkt),
        .q     (hold_pkt)
    );

    rvfi_pkt_reg u_out (
        .clk   (g_clk),
        .clear (!g_resetn),
        .load  (emit),
        .d     (out_d),
        .q     (out_q)
    );

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state      <= S_IDLE;
            rvfi_valid <= 1'b0;
            rvfi_order <= '0;
            order_q    <= ORDER_RST;
            intr_pend  <= 1'b0;
        end else begin
            rvfi_valid <= emit;
            // A trap entry coinciding with an emit belongs to the following packet.
            if (emit) begin
                rvfi_order <= order_q;
                order_q    <= order_q + ORDER_W'(1);
                intr_pend  <= wb.trap_entry;
            end else if (wb.trap_entry) begin
                intr_pend  <= 1'b1;
            end
            case (state)
                S_IDLE: if (accept && wb.wb_mem_op) state <= S_HOLD;
                S_HOLD: if (wb.dmem_rsp_valid)      state <= S_IDLE;
                default:                            state <= S_IDLE;
            endcase
        end
    end

    assign rvfi_insn      = out_q.insn;
    assign rvfi_pc_rdata  = out_q.pc_rdata;
    assign rvfi_pc_wdata  = out_q.pc_wdata;
    assign rvfi_rs1_addr  = out_q.rs1_addr;
    assign rvfi_rs2_addr  = out_q.rs2_addr;
    assign rvfi_rs1_rdata = out_q.rs1_rdata;
    assign rvfi_rs2_rdata = out_q.rs2_rdata;
    assign rvfi_rd_addr   = out_q.rd_addr;
    assign rvfi_rd_wdata  = out_q.rd_wdata;
    assign rvfi_mem_addr  = out_q.mem_addr;
    assign rvfi_mem_rmask = out_q.mem_rmask;
    assign rvfi_mem_wmask = out_q.mem_wmask;
    assign rvfi_mem_rdata = out_q.mem_rdata;
    assign rvfi_mem_wdata = out_q.mem_wdata;
    assign rvfi_trap      = out_q.trap;
    assign rvfi_intr      = out_q.intr;
    assign rvfi_halt      = 1'b0;
    assign rvfi_mode      = RVFI_MODE_M;

endmodule

// File: tb/tb_rvfi_retire_emitter.sv
// Bench for rvfi_retire_emitter: transaction-level model, per-cycle compare,
// directed literal checks, then randomized traffic.
module tb_rvfi_retire_emitter;
    import rvfi_retire_emitter_pkg::*;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    rvfi_retire_emitter_if wba ();
    rvfi_retire_emitter_if wbb ();

    // Second instance starts its counter at all-ones to exercise wrap.
    assign wbb.wb_valid       = wba.wb_valid;
    assign wbb.wb_insn        = wba.wb_insn;
    assign wbb.wb_pc          = wba.wb_pc;
    assign wbb.wb_npc         = wba.wb_npc;
    assign wbb.wb_rs1_addr    = wba.wb_rs1_addr;
    assign wbb.wb_rs1_data    = wba.wb_rs1_data;
    assign wbb.wb_rs2_addr    = wba.wb_rs2_addr;
    assign wbb.wb_rs2_data    = wba.wb_rs2_data;
    assign wbb.wb_rd_addr     = wba.wb_rd_addr;
    assign wbb.wb_rd_wdata    = wba.wb_rd_wdata;
    assign wbb.wb_trap        = wba.wb_trap;
    assign wbb.wb_mem_op      = wba.wb_mem_op;
    assign wbb.wb_mem_addr    = wba.wb_mem_addr;
    assign wbb.wb_mem_wmask   = wba.wb_mem_wmask;
    assign wbb.wb_mem_rmask   = wba.wb_mem_rmask;
    assign wbb.wb_mem_wdata   = wba.wb_mem_wdata;
    assign wbb.dmem_rsp_valid = wba.dmem_rsp_valid;
    assign wbb.dmem_rsp_rdata = wba.dmem_rsp_rdata;
    assign wbb.dmem_rsp_error = wba.dmem_rsp_error;
    assign wbb.trap_entry     = wba.trap_entry;

    logic        a_valid, b_valid, a_halt, b_halt;
    logic [63:0] a_order, b_order;
    logic [1:0]  a_mode, b_mode;
    rvfi_pkt_t   a_pkt, b_pkt;

    rvfi_retire_emitter u_dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .wb(wba.slave),
        .rvfi_valid(a_valid), .rvfi_order(a_order), .rvfi_insn(a_pkt.insn),
        .rvfi_pc_rdata(a_pkt.pc_rdata), .rvfi_pc_wdata(a_pkt.pc_wdata),
        .rvfi_rs1_addr(a_pkt.rs1_addr), .rvfi_rs2_addr(a_pkt.rs2_addr),
        .rvfi_rs1_rdata(a_pkt.rs1_rdata), .rvfi_rs2_rdata(a_pkt.rs2_rdata),
        .rvfi_rd_addr(a_pkt.rd_addr), .rvfi_rd_wdata(a_pkt.rd_wdata),
        .rvfi_mem_addr(a_pkt.mem_addr), .rvfi_mem_rmask(a_pkt.mem_rmask),
        .rvfi_mem_wmask(a_pkt.mem_wmask), .rvfi_mem_rdata(a_pkt.mem_rdata),
        .rvfi_mem_wdata(a_pkt.mem_wdata), .rvfi_trap(a_pkt.trap),
        .rvfi_halt(a_halt), .rvfi_intr(a_pkt.intr), .rvfi_mode(a_mode)
    );

    rvfi_retire_emitter #(.ORDER_RST(64'hFFFF_FFFF_FFFF_FFFF)) u_dut_wrap (
        .g_clk(g_clk), .g_resetn(g_resetn), .wb(wbb.slave),
        .rvfi_valid(b_valid), .rvfi_order(b_order), .rvfi_insn(b_pkt.insn),
        .rvfi_pc_rdata(b_pkt.pc_rdata), .rvfi_pc_wdata(b_pkt.pc_wdata),
        .rvfi_rs1_addr(b_pkt.rs1_addr), .rvfi_rs2_addr(b_pkt.rs2_addr),
        .rvfi_rs1_rdata(b_pkt.rs1_rdata), .rvfi_rs2_rdata(b_pkt.rs2_rdata),
        .rvfi_rd_addr(b_pkt.rd_addr), .rvfi_rd_wdata(b_pkt.rd_wdata),
        .rvfi_mem_addr(b_pkt.mem_addr), .rvfi_mem_rmask(b_pkt.mem_rmask),
        .rvfi_mem_wmask(b_pkt.mem_wmask), .rvfi_mem_rdata(b_pkt.mem_rdata),
        .rvfi_mem_wdata(b_pkt.mem_wdata), .rvfi_trap(b_pkt.trap),
        .rvfi_halt(b_halt), .rvfi_intr(b_pkt.intr), .rvfi_mode(b_mode)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: at most one parked memory instruction, a running
    // retirement count and a pending-interrupt flag.
    rvfi_pkt_t   exp_pkt, m_hold, mp;
    logic        exp_valid = 1'b0;
    logic [63:0] exp_order = '0, exp_order_b = '0, m_order = '0;
    logic        m_busy = 1'b0, m_pend = 1'b0, m_acc = 1'b0, memit;
    logic        chk_en = 1'b0;

    function automatic rvfi_pkt_t from_wb();
        rvfi_pkt_t p;
        p = '0;
        p.insn      = wba.wb_insn;
        p.pc_rdata  = wba.wb_pc;
        p.pc_wdata  = wba.wb_npc;
        p.rs1_addr  = wba.wb_rs1_addr;
        p.rs2_addr  = wba.wb_rs2_addr;
        p.rs1_rdata = wba.wb_rs1_data;
        p.rs2_rdata = wba.wb_rs2_data;
        p.rd_addr   = wba.wb_rd_addr;
        p.rd_wdata  = (wba.wb_rd_addr == 5'd0) ? 32'd0 : wba.wb_rd_wdata;
        p.trap      = wba.wb_trap;
        if (wba.wb_mem_op) begin
            p.mem_addr  = wba.wb_mem_addr;
            p.mem_rmask = wba.wb_mem_rmask;
            p.mem_wmask = wba.wb_mem_wmask;
            p.mem_wdata = wba.wb_mem_wdata;
        end
        return p;
    endfunction

    always @(posedge g_clk) begin
        m_acc = 1'b0;
        if (!g_resetn) begin
            exp_pkt = '0; m_hold = '0; exp_valid = 1'b0;
            exp_order = '0; exp_order_b = '0; m_order = '0;
            m_busy = 1'b0; m_pend = 1'b0;
        end else begin
            memit = 1'b0;
            mp = '0;
            if (m_busy) begin
                if (wba.dmem_rsp_valid) begin
                    mp = m_hold;
                    for (int b = 0; b < 4; b++)
                        if (mp.mem_rmask[b]) mp.mem_rdata[8*b +: 8] = wba.dmem_rsp_rdata[8*b +: 8];
                    if (wba.dmem_rsp_error) begin
                        mp.trap = 1'b1; mp.rd_addr = 5'd0; mp.rd_wdata = 32'd0;
                    end
                    memit = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (wba.wb_valid) begin
                m_acc = 1'b1;
                mp = from_wb();
                if (wba.wb_mem_op) begin
                    m_hold = mp; m_busy = 1'b1;
                end else memit = 1'b1;
            end
            exp_valid = memit;
            if (memit) begin
                mp.intr     = m_pend;
                exp_pkt     = mp;
                exp_order   = m_order;
                exp_order_b = m_order - 64'd1;
                m_order     = m_order + 64'd1;
                m_pend      = wba.trap_entry;
            end else if (wba.trap_entry) m_pend = 1'b1;
        end
    end

    always @(negedge g_clk) begin
        if (chk_en) begin
            chk("valid", a_valid, exp_valid);
            chk("wb_ready", wba.wb_ready, g_resetn && !m_busy);
            chk("order", a_order, exp_order);
            chk("insn", a_pkt.insn, exp_pkt.insn);
            chk("pc_rdata", a_pkt.pc_rdata, exp_pkt.pc_rdata);
            chk("pc_wdata", a_pkt.pc_wdata, exp_pkt.pc_wdata);
            chk("rs1", {a_pkt.rs1_addr, a_pkt.rs1_rdata}, {exp_pkt.rs1_addr, exp_pkt.rs1_rdata});
            chk("rs2", {a_pkt.rs2_addr, a_pkt.rs2_rdata}, {exp_pkt.rs2_addr, exp_pkt.rs2_rdata});
            chk("rd", {a_pkt.rd_addr, a_pkt.rd_wdata}, {exp_pkt.rd_addr, exp_pkt.rd_wdata});
            chk("mem_addr", a_pkt.mem_addr, exp_pkt.mem_addr);
            chk("mem_masks", {a_pkt.mem_rmask, a_pkt.mem_wmask}, {exp_pkt.mem_rmask, exp_pkt.mem_wmask});
            chk("mem_rdata", a_pkt.mem_rdata, exp_pkt.mem_rdata);
            chk("mem_wdata", a_pkt.mem_wdata, exp_pkt.mem_wdata);
            chk("trap_intr", {a_pkt.trap, a_pkt.intr}, {exp_pkt.trap, exp_pkt.intr});
            chk("halt_mode", {a_halt, a_mode}, 3'b011);
            chk("b_valid", b_valid, exp_valid);
            chk("b_order", b_order, exp_order_b);
            chk("b_pkt_eq", (b_pkt == exp_pkt) && !b_halt && (b_mode == 2'b11), 1'b1);
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic clr_in();
        wba.wb_valid = 0; wba.wb_insn = 0; wba.wb_pc = 0; wba.wb_npc = 0;
        wba.wb_rs1_addr = 0; wba.wb_rs1_data = 0; wba.wb_rs2_addr = 0; wba.wb_rs2_data = 0;
        wba.wb_rd_addr = 0; wba.wb_rd_wdata = 0; wba.wb_trap = 0; wba.wb_mem_op = 0;
        wba.wb_mem_addr = 0; wba.wb_mem_wmask = 0; wba.wb_mem_rmask = 0; wba.wb_mem_wdata = 0;
        wba.dmem_rsp_valid = 0; wba.dmem_rsp_rdata = 0; wba.dmem_rsp_error = 0; wba.trap_entry = 0;
    endtask

    task automatic drive_wb(input logic [31:0] insn, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] rdw, input logic mem, input logic [31:0] addr,
                            input logic [3:0] rm, input logic [3:0] wm);
        wba.wb_valid = 1; wba.wb_insn = insn; wba.wb_pc = pc; wba.wb_npc = pc + 32'd4;
        wba.wb_rs1_addr = 5'($urandom_range(0, 31)); wba.wb_rs1_data = $urandom;
        wba.wb_rs2_addr = 5'($urandom_range(0, 31)); wba.wb_rs2_data = $urandom;
        wba.wb_rd_addr = rd; wba.wb_rd_wdata = rdw; wba.wb_trap = 0; wba.wb_mem_op = mem;
        wba.wb_mem_addr = addr; wba.wb_mem_rmask = rm; wba.wb_mem_wmask = wm;
        wba.wb_mem_wdata = $urandom;
    endtask

    logic pending;

    initial begin
        clr_in();
        g_resetn = 0;
        tick();
        chk_en = 1;
        chk("lit_rst_ready", wba.wb_ready, 1'b0);
        chk("lit_rst_valid", a_valid, 1'b0);
        tick(); tick();
        g_resetn = 1;

        drive_wb(32'h0010_8093, 32'h100, 5'd1, 32'd5, 1'b0, 32'h0, 4'h0, 4'h0);
        tick();
        wba.wb_valid = 0;
        chk("lit_alu_valid", a_valid, 1'b1);
        chk("lit_alu_order", a_order, 64'd0);
        chk("lit_alu_pc_wdata", a_pkt.pc_wdata, 64'h104);
        chk("lit_alu_rd_wdata", a_pkt.rd_wdata, 64'd5);
        chk("lit_wrap_order_max", b_order, 64'hFFFF_FFFF_FFFF_FFFF);

        drive_wb(32'h0000_2103, 32'h104, 5'd2, 32'd0, 1'b1, 32'h2000, 4'hF, 4'h0);
        tick();
        wba.wb_valid = 0; wba.wb_mem_op = 0;
        chk("lit_load_hold_valid", a_valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("lit_load_hold_ready", wba.wb_ready, 1'b0);
            tick();
        end
        wba.dmem_rsp_valid = 1; wba.dmem_rsp_rdata = 32'hDEAD_BEEF;
        tick();
        wba.dmem_rsp_valid = 0;
        chk("lit_load_valid", a_valid, 1'b1);
        chk("lit_load_rdata", a_pkt.mem_rdata, 64'hDEAD_BEEF);
        chk("lit_load_order", a_order, 64'd1);
        chk("lit_wrap_order_zero", b_order, 64'd0);
        tick();
        chk("lit_load_single", a_valid, 1'b0);

        drive_wb(32'h0000_0013, 32'h108, 5'd0, 32'h1234, 1'b0, 32'h0, 4'h0, 4'h0);
        tick();
        wba.wb_valid = 0;
        chk("lit_rd0_wdata", a_pkt.rd_wdata, 64'd0);

        wba.trap_entry = 1;
        tick();
        wba.trap_entry = 0;
        drive_wb(32'h0000_0013, 32'h80, 5'd4, 32'd9, 1'b0, 32'h0, 4'h0, 4'h0);
        tick();
        chk("lit_intr_first", {a_pkt.pc_rdata, 1'b0, a_pkt.intr}, {32'h80, 1'b0, 1'b1});
        drive_wb(32'h0000_0013, 32'h84, 5'd4, 32'd10, 1'b0, 32'h0, 4'h0, 4'h0);
        tick();
        wba.wb_valid = 0;
        chk("lit_intr_second", a_pkt.intr, 1'b0);

        drive_wb(32'h0000_2183, 32'h88, 5'd3, 32'h77, 1'b1, 32'h3000, 4'h3, 4'h0);
        tick();
        wba.wb_valid = 0; wba.wb_mem_op = 0;
        tick();
        wba.dmem_rsp_valid = 1; wba.dmem_rsp_error = 1; wba.dmem_rsp_rdata = 32'h1122_3344;
        tick();
        wba.dmem_rsp_valid = 0; wba.dmem_rsp_error = 0;
        chk("lit_err_trap", a_pkt.trap, 1'b1);
        chk("lit_err_rd", {a_pkt.rd_addr, a_pkt.rd_wdata}, 37'd0);
        chk("lit_err_rdata", a_pkt.mem_rdata, 64'h3344);
        chk("lit_err_order", a_order, 64'd5);

        drive_wb(32'h0000_2203, 32'h8C, 5'd4, 32'd0, 1'b1, 32'h4000, 4'hF, 4'h0);
        tick();
        wba.wb_valid = 0; wba.wb_mem_op = 0;
        g_resetn = 0; wba.dmem_rsp_valid = 1; wba.dmem_rsp_rdata = 32'hCAFE_F00D;
        tick();
        g_resetn = 1; wba.dmem_rsp_valid = 0;
        chk("lit_rst_hold_valid", a_valid, 1'b0);
        chk("lit_rst_hold_order", a_order, 64'd0);
        tick();
        chk("lit_rst_hold_nopkt", a_valid, 1'b0);
        drive_wb(32'h0010_8093, 32'h200, 5'd1, 32'd7, 1'b0, 32'h0, 4'h0, 4'h0);
        tick();
        wba.wb_valid = 0;
        chk("lit_rst_hold_first_order", {a_valid, a_order}, {1'b1, 64'd0});

        pending = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pending && $urandom_range(0, 2) != 0) begin
                drive_wb($urandom, $urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)), $urandom,
                         1'($urandom_range(0, 1)), $urandom, 4'($urandom), 4'($urandom));
                wba.wb_trap = 1'($urandom_range(0, 7) == 0);
                pending = 1;
            end
            wba.dmem_rsp_valid = ($urandom_range(0, 3) == 0);
            wba.dmem_rsp_rdata = $urandom;
            wba.dmem_rsp_error = ($urandom_range(0, 7) == 0);
            wba.trap_entry     = ($urandom_range(0, 9) == 0);
            g_resetn           = ($urandom_range(0, 299) != 0);
            tick();
            if (m_acc) begin
                pending = 0;
                wba.wb_valid = 0;
            end
        end

        clr_in();
        g_resetn = 1;
        tick(); tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
